// File: rtl/vram_pkg.sv
// Shared defaults, vertical-blank boundary row and state/slot encodings
// for the double-buffered pixel RAM arbiter.
package vram_pkg;

  localparam int XW_DEF = 8;
  localparam int YW_DEF = 8;
  localparam int DW_DEF = 8;

  // First row of vertical blank; bank swaps are aligned to its first pixel tick.
  localparam int VD = 480;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_PROC = 2'd2
  } slot_e;

endpackage

// File: rtl/vram_swap_ctrl.sv
// Bank-swap controller: latches a swap request and flips the displayed bank
// at the next vertical-blank boundary, pulsing swap_done_o afterwards.
module vram_swap_ctrl
  import vram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic swap_req_i,
  input  logic boundary_i,
  output logic swap_cycle_o,
  output logic disp_bank_o,
  output logic swap_done_o
);

  swap_state_e state_q, state_d;
  logic        bank_q, bank_d;
  logic        done_q, done_d;

  // Swap FSM next state; swap_cycle_o marks the cycle whose end flips the bank.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    done_d       = 1'b0;
    swap_cycle_o = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req_i) begin
          state_d = SWAP_PENDING;
        end else begin
          state_d = SWAP_IDLE;
        end
      end
      SWAP_PENDING: begin
        if (boundary_i) begin
          swap_cycle_o = 1'b1;
          bank_d       = ~bank_q;
          done_d       = 1'b1;
          state_d      = SWAP_IDLE;
        end else begin
          state_d = SWAP_PENDING;
        end
      end
      default: begin
        state_d = SWAP_IDLE;
      end
    endcase
  end

  // State, bank and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWAP_IDLE;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  assign disp_bank_o = bank_q;
  assign swap_done_o = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port pixel RAM between the display fetch (priority on
// in-window pixel ticks) and the filter processor, with double-buffered banks.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter  int XW = XW_DEF,
  parameter  int YW = YW_DEF,
  parameter  int DW = DW_DEF,
  localparam int AW = XW + YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          proc_req,
  input  logic          proc_we,
  input  logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_wdata,
  output logic          proc_gnt,
  output logic          proc_rvalid,
  output logic [DW-1:0] proc_rdata,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          disp_bank,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid
);

  localparam logic [10:0] IMG_W_L = 11'(2 ** XW);
  localparam logic [10:0] IMG_H_L = 11'(2 ** YW);

  logic    in_window_s;
  logic    boundary_s;
  logic    swap_cycle_s;
  slot_e   slot_s;

  logic    disp_tag_q, disp_tag_d;
  logic    blank_tag_q, blank_tag_d;
  logic    proc_tag_q, proc_tag_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic    pix_valid_q, pix_valid_d;

  assign in_window_s = video_on && ({1'b0, pixel_x} < IMG_W_L) && ({1'b0, pixel_y} < IMG_H_L);
  assign boundary_s  = p_tick && (pixel_y == 10'(VD)) && (pixel_x == 10'd0);

  vram_swap_ctrl u_swap (
    .clk          (clk),
    .rst_n        (rst_n),
    .swap_req_i   (swap_req),
    .boundary_i   (boundary_s),
    .swap_cycle_o (swap_cycle_s),
    .disp_bank_o  (disp_bank),
    .swap_done_o  (swap_done)
  );

  // Slot decision and RAM command; the bus stays quiet while reset is held.
  always_comb begin
    slot_s    = SLOT_IDLE;
    proc_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst_n) begin
      slot_s = SLOT_IDLE;
    end else if (p_tick && in_window_s) begin
      slot_s   = SLOT_DISP;
      mem_en   = 1'b1;
      mem_addr = {disp_bank, pixel_y[YW-1:0], pixel_x[XW-1:0]};
    end else if (proc_req && !swap_cycle_s) begin
      slot_s    = SLOT_PROC;
      proc_gnt  = 1'b1;
      mem_en    = 1'b1;
      mem_we    = proc_we;
      mem_addr  = {~disp_bank, proc_addr};
      mem_wdata = proc_wdata;
    end else begin
      slot_s = SLOT_IDLE;
    end
  end

  // Read-return tags and display pixel pipeline next state.
  always_comb begin
    disp_tag_d  = (slot_s == SLOT_DISP);
    blank_tag_d = rst_n && p_tick && !in_window_s;
    proc_tag_d  = (slot_s == SLOT_PROC) && !proc_we;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    if (disp_tag_q) begin
      pix_data_d  = mem_rdata;
      pix_valid_d = 1'b1;
    end else if (blank_tag_q) begin
      pix_data_d  = '0;
      pix_valid_d = 1'b0;
    end else begin
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;
    end
  end

  // Tag and pixel registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_tag_q  <= 1'b0;
      blank_tag_q <= 1'b0;
      proc_tag_q  <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      disp_tag_q  <= disp_tag_d;
      blank_tag_q <= blank_tag_d;
      proc_tag_q  <= proc_tag_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  // Processor read data is the RAM output qualified by the registered tag.
  assign proc_rvalid = proc_tag_q;
  assign proc_rdata  = proc_tag_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, scoreboard queues for
// display pixels and processor read returns, one task per scenario.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_tick, video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        proc_req, proc_we;
  logic [15:0] proc_addr;
  logic [7:0]  proc_wdata;
  logic        proc_gnt, proc_rvalid;
  logic [7:0]  proc_rdata;
  logic        swap_req, swap_done, disp_bank;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pix_data;
  logic        pix_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { int due; logic v; logic [7:0] d; } pix_exp_t;
  typedef struct { int due; logic [7:0] d; } prd_exp_t;
  pix_exp_t pix_q[$];
  prd_exp_t prd_q[$];
  pix_exp_t pe;
  prd_exp_t re;

  logic [7:0] ram [logic [16:0]];

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .proc_req(proc_req), .proc_we(proc_we),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_gnt(proc_gnt),
    .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata), .swap_req(swap_req),
    .swap_done(swap_done), .disp_bank(disp_bank), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Initial RAM contents: pat(0x00305) = 0xA5.
  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'd0} ^ 8'hA3;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : pat(mem_addr);
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      checks++;
      if (pix_valid !== pe.v || pix_data !== pe.d) begin
        errors++;
        $display("FAIL pix @%0d: got valid=%b data=%h, want valid=%b data=%h", cyc, pix_valid, pix_data, pe.v, pe.d);
      end
    end
    checks++;
    if (prd_q.size() > 0 && prd_q[0].due == cyc) begin
      re = prd_q.pop_front();
      if (proc_rvalid !== 1'b1 || proc_rdata !== re.d) begin
        errors++;
        $display("FAIL proc_read @%0d: got rvalid=%b rdata=%h, want rvalid=1 rdata=%h", cyc, proc_rvalid, proc_rdata, re.d);
      end
    end else if (proc_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_quiet @%0d: got rvalid=%b, want 0", cyc, proc_rvalid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pt, input logic von, input logic [9:0] x, input logic [9:0] y,
                       input logic req, input logic we, input logic [15:0] a, input logic [7:0] wd,
                       input logic swp);
    p_tick = pt; video_on = von; pixel_x = x; pixel_y = y;
    proc_req = req; proc_we = we; proc_addr = a; proc_wdata = wd; swap_req = swp;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 10'd10, 10'd20, 1'b1, 1'b0, 16'h0102, 8'h00, 1'b0);
    repeat (3) step();
    checks++;
    if ({proc_gnt, mem_en, mem_we, proc_rvalid, pix_valid, swap_done, disp_bank} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt/en/we/rv/pv/sd/db=%b, want 0000000",
               {proc_gnt, mem_en, mem_we, proc_rvalid, pix_valid, swap_done, disp_bank});
    end
    checks++;
    if (mem_addr !== 17'h0 || proc_rdata !== 8'h00 || pix_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got addr=%h rdata=%h pix=%h, want 0", mem_addr, proc_rdata, pix_data);
    end
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 10'd10, 10'd20, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 17'h0140A) begin
      errors++;
      $display("FAIL reset_first_disp: got en=%b addr=%h, want en=1 addr=0140a", mem_en, mem_addr);
    end
    pix_q.push_back('{cyc + 2, 1'b1, pat(17'h0140A)});
    step(); idle();
  endtask

  task automatic test_display();
    step();
    drive(1'b1, 1'b1, 10'd5, 10'd3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00305 || proc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL disp_addr: got en=%b we=%b addr=%h gnt=%b, want 1 0 00305 0", mem_en, mem_we, mem_addr, proc_gnt);
    end
    pix_q.push_back('{cyc + 2, 1'b1, 8'hA5});
    step(); idle();
    step();
    drive(1'b1, 1'b1, 10'd300, 10'd3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL disp_outside_en: got en=%b, want 0", mem_en);
    end
    pix_q.push_back('{cyc + 2, 1'b0, 8'h00});
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_contention();
    logic [15:0] a;
    for (int x = 0; x < 264; x++) begin
      a = 16'h8000 + 16'(x);
      step();
      drive(1'b1, 1'b1, 10'(x), 10'd10, 1'b1, 1'b1, a, 8'(x), 1'b0);
      #1;
      checks++;
      if (x < 256) begin
        if (proc_gnt !== 1'b0 || mem_addr !== {1'b0, 8'd10, 8'(x)}) begin
          errors++;
          $display("FAIL contend_disp x=%0d: got gnt=%b addr=%h, want gnt=0 addr=%h", x, proc_gnt, mem_addr, {1'b0, 8'd10, 8'(x)});
        end
        pix_q.push_back('{cyc + 2, 1'b1, pat({1'b0, 8'd10, 8'(x)})});
      end else begin
        if (proc_gnt !== 1'b1 || mem_addr !== {1'b1, a}) begin
          errors++;
          $display("FAIL contend_out x=%0d: got gnt=%b addr=%h, want gnt=1 addr=%h", x, proc_gnt, mem_addr, {1'b1, a});
        end
        pix_q.push_back('{cyc + 2, 1'b0, 8'h00});
      end
      step();
      drive(1'b0, 1'b1, 10'(x), 10'd10, 1'b1, 1'b1, a, 8'(x), 1'b0);
      #1;
      checks++;
      if (proc_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {1'b1, a} || mem_wdata !== 8'(x)) begin
        errors++;
        $display("FAIL contend_proc x=%0d: got gnt=%b we=%b addr=%h wd=%h, want 1 1 %h %h", x, proc_gnt, mem_we, mem_addr, mem_wdata, {1'b1, a}, 8'(x));
      end
    end
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_proc_read();
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd3, 1'b1, 1'b1, 16'h0102, 8'h3C, 1'b0);
    #1;
    checks++;
    if (proc_gnt !== 1'b1 || mem_addr !== 17'h10102) begin
      errors++;
      $display("FAIL proc_write: got gnt=%b addr=%h, want 1 10102", proc_gnt, mem_addr);
    end
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd3, 1'b1, 1'b0, 16'h0102, 8'h00, 1'b0);
    #1;
    checks++;
    if (proc_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h10102) begin
      errors++;
      $display("FAIL proc_read_issue: got gnt=%b we=%b addr=%h, want 1 0 10102", proc_gnt, mem_we, mem_addr);
    end
    prd_q.push_back('{cyc + 1, 8'h3C});
    step();
    drive(1'b1, 1'b1, 10'd7, 10'd3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 17'h00307) begin
      errors++;
      $display("FAIL read_then_disp: got en=%b addr=%h, want 1 00307", mem_en, mem_addr);
    end
    pix_q.push_back('{cyc + 2, 1'b1, pat(17'h00307)});
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_swap();
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b0, 1'b1, 10'd0, 10'd100, 1'b0, 1'b0, 16'h0000, 8'h00, (i == 1));
      #1;
      checks++;
      if (disp_bank !== 1'b0 || swap_done !== 1'b0) begin
        errors++;
        $display("FAIL swap_pending %0d: got bank=%b done=%b, want 0 0", i, disp_bank, swap_done);
      end
    end
    step();
    drive(1'b1, 1'b0, 10'd0, 10'd480, 1'b1, 1'b1, 16'h1234, 8'h55, 1'b0);
    #1;
    checks++;
    if (proc_gnt !== 1'b0 || mem_en !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL swap_cycle: got gnt=%b en=%b bank=%b, want 0 0 0", proc_gnt, mem_en, disp_bank);
    end
    step(); idle();
    #1;
    checks++;
    if (disp_bank !== 1'b1 || swap_done !== 1'b1) begin
      errors++;
      $display("FAIL swap_effect: got bank=%b done=%b, want 1 1", disp_bank, swap_done);
    end
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'h0001, 8'h11, 1'b0);
    #1;
    checks++;
    if (swap_done !== 1'b0 || proc_gnt !== 1'b1 || mem_addr !== 17'h00001) begin
      errors++;
      $display("FAIL swap_after: got done=%b gnt=%b addr=%h, want 0 1 00001", swap_done, proc_gnt, mem_addr);
    end
    step();
    drive(1'b1, 1'b1, 10'd5, 10'd3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checks++;
    if (mem_addr !== 17'h10305) begin
      errors++;
      $display("FAIL swap_disp_bank1: got addr=%h, want 10305", mem_addr);
    end
    step();
    drive(1'b1, 1'b0, 10'd0, 10'd480, 1'b1, 1'b1, 16'h0002, 8'h22, 1'b0);
    #1;
    checks++;
    if (proc_gnt !== 1'b1) begin
      errors++;
      $display("FAIL swap_no_requeue_gnt: got gnt=%b, want 1", proc_gnt);
    end
    step(); idle();
    #1;
    checks++;
    if (swap_done !== 1'b0 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL swap_no_requeue: got done=%b bank=%b, want 0 1", swap_done, disp_bank);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_outstanding();
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b1, 10'd0, 10'd100, 1'b1, 1'b0, 16'h0102, 8'h00, 1'b0);
    #1;
    checks++;
    if (proc_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_out_gnt: got gnt=%b, want 1", proc_gnt);
    end
    step();
    rst_n = 1'b0;
    idle();
    #1;
    checks++;
    if (proc_rvalid !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_drop: got rvalid=%b bank=%b, want 0 0", proc_rvalid, disp_bank);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    step(); idle();
    #1;
    checks++;
    if (swap_done !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_swap_cancel: got done=%b bank=%b, want 0 0", swap_done, disp_bank);
    end
    repeat (2) step();
  endtask

  task automatic test_swap_coincident();
    step();
    drive(1'b1, 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(); idle();
    #1;
    checks++;
    if (swap_done !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL coincident_wait: got done=%b bank=%b, want 0 0", swap_done, disp_bank);
    end
    repeat (2) step();
    drive(1'b1, 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    step(); idle();
    #1;
    checks++;
    if (swap_done !== 1'b1 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL coincident_swap: got done=%b bank=%b, want 1 1", swap_done, disp_bank);
    end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_display();
    test_contention();
    test_proc_read();
    test_swap();
    test_reset_outstanding();
    test_swap_coincident();
    repeat (4) step();
    checks++;
    if (pix_q.size() != 0 || prd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pix and %0d read items left, want 0", pix_q.size(), prd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
